// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for register-to-register ALU ops; optional SINGLE_STEP_EN adds a step port and HOLD state.
// Latency: 3-operand 6 cycles, MUL/DIV 7, NEG/NOT 5, illegal 4 (plus T1 wait cycles).
// Backpressure: T1 stalls on mem_ready and aborts to IDLE after MEM_TIMEOUT wait cycles.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDMuxread,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [12:0] alu_sel,
  output logic        busy,
  output logic        done,
  output logic        illegal_op,
  output logic        mem_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
`ifdef SINGLE_STEP_EN
    , S_HOLD
`endif
  } state_t;

  state_t      state;
  state_t      boundary_next;
  logic [3:0]  wait_cnt;
  logic [4:0]  opc;
  logic [3:0]  ra, rb, rc;
  logic [12:0] alu_op;
  logic        op_legal, is_unary, is_muldiv;
  logic        ir_unused;

  assign opc       = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign ir_unused = ^ir[14:0];
  assign is_unary  = alu_op[11] | alu_op[12];
  assign is_muldiv = alu_op[2] | alu_op[3];

  always_comb begin
    alu_op   = '0;
    op_legal = 1'b1;
    case (opc)
      5'b00000: alu_op = 13'h0001; // ADD
      5'b00001: alu_op = 13'h0002; // SUB
      5'b00010: alu_op = 13'h0010; // AND
      5'b00011: alu_op = 13'h0020; // OR
      5'b00100: alu_op = 13'h0100; // SHL
      5'b00101: alu_op = 13'h0040; // SHR
      5'b00110: alu_op = 13'h0080; // SHRA
      5'b00111: alu_op = 13'h0200; // ROR
      5'b01000: alu_op = 13'h0400; // ROL
      5'b01111: alu_op = 13'h0004; // MUL
      5'b10000: alu_op = 13'h0008; // DIV
      5'b10001: alu_op = 13'h0800; // NEG
      5'b10010: alu_op = 13'h1000; // NOT
      default:  op_legal = 1'b0;
    endcase
  end

`ifdef SINGLE_STEP_EN
  assign boundary_next = run ? S_HOLD : S_IDLE;
`else
  assign boundary_next = run ? S_T0 : S_IDLE;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          wait_cnt <= '0;
        end
        S_T1: begin
          if (mem_ready) begin
            state    <= S_T2;
            wait_cnt <= '0;
          end else if (wait_cnt == 4'(MEM_TIMEOUT)) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_T2: state <= S_T3;
        S_T3: state <= op_legal ? S_T4 : boundary_next;
        S_T4: state <= is_unary ? boundary_next : S_T5;
        S_T5: state <= is_muldiv ? S_T6 : boundary_next;
        S_T6: state <= boundary_next;
`ifdef SINGLE_STEP_EN
        S_HOLD: begin
          if (!run)      state <= S_IDLE;
          else if (step) state <= S_T0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are a pure decode of the current step so each one spans exactly one full clock.
  always_comb begin
    Rin = '0; Rout = '0; alu_sel = '0;
    PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; MDMuxread = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    LOin = 1'b0; HIin = 1'b0;
    busy = 1'b0; done = 1'b0; illegal_op = 1'b0; mem_timeout = 1'b0;
    if (!clear) begin
      busy = (state != S_IDLE);
      case (state)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        end
        S_T1: begin
          MDMuxread = 1'b1;
          if (wait_cnt == 4'd0) begin
            Zlowout = 1'b1; PCin = 1'b1;
          end
          MDRin       = mem_ready;
          mem_timeout = !mem_ready && (wait_cnt == 4'(MEM_TIMEOUT));
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          if (!op_legal) begin
            illegal_op = 1'b1;
          end else if (is_unary) begin
            Rout = 16'd1 << rb; alu_sel = alu_op; Zlowin = 1'b1;
          end else begin
            Rout = 16'd1 << rb; Yin = 1'b1;
          end
        end
        S_T4: begin
          if (is_unary) begin
            Zlowout = 1'b1; Rin = 16'd1 << ra; done = 1'b1;
          end else begin
            Rout = 16'd1 << rc; alu_sel = alu_op; Zlowin = 1'b1;
            Zhighin = is_muldiv;
          end
        end
        S_T5: begin
          if (is_muldiv) begin
            Zlowout = 1'b1; LOin = 1'b1;
          end else begin
            Zlowout = 1'b1; Rin = 16'd1 << ra; done = 1'b1;
          end
        end
        S_T6: begin
          Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
